// File: rtl/vco_sweep_ctrl_if.sv
// vco_sweep_ctrl_if
//   Bundles the sweep controller's control/status signals and its VCO output.
//   The master side is the cutting-control logic. It issues start/abort and the sweep
//   settings, and it reads busy/done/step_tick/increment.
//   The slave side is vco_sweep_ctrl.
// Signals:
//   start, abort                 sweep request / immediate stop
//   start_inc, stop_inc, step_inc  sweep limits and step magnitude (INC_W bits)
//   dwell                        cycles each point is held (DWELL_W bits, 0 acts as 1)
//   increment                    current VCO increment
//   busy, done, step_tick        sweep status and per-point strobe
interface vco_sweep_ctrl_if #(
  parameter int INC_W   = 15,
  parameter int DWELL_W = 24
);
  logic               start;
  logic               abort;
  logic [INC_W-1:0]   start_inc;
  logic [INC_W-1:0]   stop_inc;
  logic [INC_W-1:0]   step_inc;
  logic [DWELL_W-1:0] dwell;
  logic [INC_W-1:0]   increment;
  logic               busy;
  logic               done;
  logic               step_tick;

  modport master (
    output start, abort, start_inc, stop_inc, step_inc, dwell,
    input  increment, busy, done, step_tick
  );

  modport slave (
    input  start, abort, start_inc, stop_inc, step_inc, dwell,
    output increment, busy, done, step_tick
  );
endinterface

// File: rtl/vco_sweep_ctrl.sv
// vco_sweep_ctrl
//   Steps the VCO increment linearly from start_inc to stop_inc. The sweep runs up or
//   down, and each point is held for max(dwell,1) clock cycles. The last point is always
//   clamped to exactly stop_inc.
//   step_tick marks the first cycle of every new point so that downstream measurement
//   logic can take one sample per frequency.
// Ports:
//   clk50MHz  system clock, rising edge
//   rst       asynchronous active-high reset
//   bus       vco_sweep_ctrl_if.slave carrying start/abort, sweep settings,
//             increment, busy, done and step_tick
module vco_sweep_ctrl #(
  parameter int INC_W   = 15,
  parameter int DWELL_W = 24
) (
  input  logic              clk50MHz,
  input  logic              rst,
  vco_sweep_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  state_t             state_reg, state_next;
  logic [INC_W-1:0]   increment_reg, increment_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               step_tick_reg, step_tick_next;
  logic [DWELL_W-1:0] dwell_cnt_reg, dwell_cnt_next;
  // Settings captured when a sweep is accepted; input changes mid-sweep are ignored.
  logic [INC_W-1:0]   stop_reg, stop_next;
  logic [INC_W-1:0]   step_reg, step_next;
  logic [DWELL_W-1:0] dwell_m1_reg, dwell_m1_next;
  logic               dir_up_reg, dir_up_next;

  // The next point is computed one bit wider, so an overflow going up or a borrow
  // going down is visible and clamps to stop instead of wrapping.
  logic [INC_W:0]     sum_w;
  logic [INC_W:0]     diff_w;
  logic [INC_W-1:0]   next_point;

  always_comb begin
    sum_w  = {1'b0, increment_reg} + {1'b0, step_reg};
    diff_w = {1'b0, increment_reg} - {1'b0, step_reg};
    if (dir_up_reg) begin
      next_point = (sum_w >= {1'b0, stop_reg}) ? stop_reg : sum_w[INC_W-1:0];
    end else begin
      next_point = (diff_w[INC_W] || (diff_w[INC_W-1:0] <= stop_reg))
                   ? stop_reg : diff_w[INC_W-1:0];
    end
  end

  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      increment_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      step_tick_reg <= 1'b0;
      dwell_cnt_reg <= '0;
      stop_reg      <= '0;
      step_reg      <= '0;
      dwell_m1_reg  <= '0;
      dir_up_reg    <= 1'b1;
    end else begin
      state_reg     <= state_next;
      increment_reg <= increment_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      step_tick_reg <= step_tick_next;
      dwell_cnt_reg <= dwell_cnt_next;
      stop_reg      <= stop_next;
      step_reg      <= step_next;
      dwell_m1_reg  <= dwell_m1_next;
      dir_up_reg    <= dir_up_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    increment_next = increment_reg;   // VCO keeps its last frequency when idle
    busy_next      = busy_reg;
    done_next      = 1'b0;
    step_tick_next = 1'b0;
    dwell_cnt_next = dwell_cnt_reg;
    stop_next      = stop_reg;
    step_next      = step_reg;
    dwell_m1_next  = dwell_m1_reg;
    dir_up_next    = dir_up_reg;

    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        if (bus.start) begin
          stop_next      = bus.stop_inc;
          step_next      = bus.step_inc;
          dir_up_next    = (bus.stop_inc >= bus.start_inc);
          dwell_m1_next  = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);
          dwell_cnt_next = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);
          // A zero step could never reach stop, so the sweep collapses to stop alone.
          increment_next = (bus.step_inc == '0) ? bus.stop_inc : bus.start_inc;
          busy_next      = 1'b1;
          step_tick_next = 1'b1;
          state_next     = HOLD;
        end
      end
      HOLD: begin
        if (bus.abort) begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (dwell_cnt_reg != '0) begin
          dwell_cnt_next = dwell_cnt_reg - DWELL_W'(1);
        end else if (increment_reg == stop_reg) begin
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = DONE;
        end else begin
          increment_next = next_point;
          step_tick_next = 1'b1;
          dwell_cnt_next = dwell_m1_reg;
        end
      end
      DONE: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign bus.increment = increment_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.step_tick = step_tick_reg;

endmodule

// File: tb/tb_vco_sweep_ctrl.sv
// tb_vco_sweep_ctrl
//   Directed sweeps with hand-computed point lists. Each sweep pushes its expected
//   step_tick values and final done into a queue. A monitor pops one entry per
//   step_tick/done pulse and checks the value and the spacing in cycles from the
//   previous event.
module tb_vco_sweep_ctrl;
  localparam int INC_W   = 15;
  localparam int DWELL_W = 24;

  logic clk50MHz;
  logic rst;

  vco_sweep_ctrl_if #(.INC_W(INC_W), .DWELL_W(DWELL_W)) bus ();

  vco_sweep_ctrl #(.INC_W(INC_W), .DWELL_W(DWELL_W)) dut (
    .clk50MHz (clk50MHz),
    .rst      (rst),
    .bus      (bus)
  );

  initial begin
    clk50MHz = 1'b0;
    forever #10 clk50MHz = ~clk50MHz;
  end

  typedef struct {
    bit is_done;
    int val;
    int gap;     // expected cycles since previous event, -1 = don't care
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void chk(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endfunction

  task automatic push_tick(input int v, input int g);
    exp_t e;
    e.is_done = 1'b0;
    e.val     = v;
    e.gap     = g;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int g);
    exp_t e;
    e.is_done = 1'b1;
    e.val     = 0;
    e.gap     = g;
    exp_q.push_back(e);
  endtask

  // Monitor: consumes one scoreboard entry per step_tick or done pulse.
  initial begin
    int cyc;
    int last_evt;
    int last_val;
    exp_t e;
    cyc      = 0;
    last_evt = 0;
    last_val = 0;
    forever begin
      @(negedge clk50MHz);
      cyc++;
      if (!rst) begin
        if (bus.step_tick) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_step_tick", int'(bus.increment), -1);
          end else begin
            e = exp_q.pop_front();
            chk("tick_kind", int'(e.is_done), 0);
            chk("tick_increment", int'(bus.increment), e.val);
            if (e.gap >= 0) chk("tick_spacing", cyc - last_evt, e.gap);
          end
          last_evt = cyc;
          last_val = int'(bus.increment);
        end else if (bus.busy) begin
          if (int'(bus.increment) != last_val)
            chk("increment_stable", int'(bus.increment), last_val);
        end
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("done_kind", int'(e.is_done), 1);
            chk("done_busy_low", int'(bus.busy), 0);
            if (e.gap >= 0) chk("done_spacing", cyc - last_evt, e.gap);
          end
          last_evt = cyc;
        end
      end
    end
  end

  // Issues one sweep, counts busy cycles and checks the sweep end state.
  // With disturb set, a start pulse and new settings are driven mid-sweep, and both
  // must be ignored.
  task automatic run_sweep(input int s, input int e, input int st, input int d,
                           input int exp_busy, input int final_val, input bit disturb);
    int busy_cnt;
    int guard;
    @(negedge clk50MHz);
    bus.start_inc = INC_W'(s);
    bus.stop_inc  = INC_W'(e);
    bus.step_inc  = INC_W'(st);
    bus.dwell     = DWELL_W'(d);
    bus.start     = 1'b1;
    @(negedge clk50MHz);
    bus.start = 1'b0;
    busy_cnt  = 0;
    guard     = 0;
    while (bus.busy && guard < 400) begin
      busy_cnt++;
      if (disturb && busy_cnt == 2) begin
        bus.start     = 1'b1;
        bus.start_inc = INC_W'(0);
        bus.stop_inc  = INC_W'(7);
        bus.step_inc  = INC_W'(1);
        bus.dwell     = DWELL_W'(5);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk50MHz);
      guard++;
    end
    bus.start = 1'b0;
    chk("busy_cycles", busy_cnt, exp_busy);
    @(negedge clk50MHz);
    @(negedge clk50MHz);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("increment_after_sweep", int'(bus.increment), final_val);
    chk("busy_after_sweep", int'(bus.busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.start_inc = '0;
    bus.stop_inc  = '0;
    bus.step_inc  = '0;
    bus.dwell     = '0;
    rst           = 1'b1;
    #5;
    chk("reset_increment", int'(bus.increment), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_step_tick", int'(bus.step_tick), 0);
    repeat (2) @(negedge clk50MHz);
    rst = 1'b0;

    // Up sweep: 26000, 26005, 26010, 3 cycles each.
    push_tick(26000, -1); push_tick(26005, 3); push_tick(26010, 3); push_done(3);
    run_sweep(26000, 26010, 5, 3, 9, 26010, 1'b0);

    // Clamp on the last step, with inputs disturbed mid-sweep.
    push_tick(100, -1); push_tick(104, 1); push_tick(108, 1); push_tick(110, 1); push_done(1);
    run_sweep(100, 110, 4, 1, 4, 110, 1'b1);

    // Down sweep where the last step borrows.
    push_tick(5, -1); push_tick(2, 2); push_tick(0, 2); push_done(2);
    run_sweep(5, 0, 3, 2, 6, 0, 1'b0);

    // Down sweep clamped to stop.
    push_tick(30, -1); push_tick(26, 1); push_tick(22, 1); push_tick(21, 1); push_done(1);
    run_sweep(30, 21, 4, 1, 4, 21, 1'b0);

    // step=0 collapses to the single point stop_inc.
    push_tick(20, -1); push_done(2);
    run_sweep(10, 20, 0, 2, 2, 20, 1'b0);

    // start==stop: one point.
    push_tick(500, -1); push_done(2);
    run_sweep(500, 500, 7, 2, 2, 500, 1'b0);

    // Abort during the second point.
    push_tick(26000, -1); push_tick(26005, 3);
    @(negedge clk50MHz);
    bus.start_inc = INC_W'(26000);
    bus.stop_inc  = INC_W'(26010);
    bus.step_inc  = INC_W'(5);
    bus.dwell     = DWELL_W'(3);
    bus.start     = 1'b1;
    @(negedge clk50MHz);
    bus.start = 1'b0;
    repeat (4) @(negedge clk50MHz);
    bus.abort = 1'b1;
    @(negedge clk50MHz);
    bus.abort = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_increment", int'(bus.increment), 26005);
    repeat (6) @(negedge clk50MHz);
    chk("abort_increment_held", int'(bus.increment), 26005);
    chk("abort_scoreboard", exp_q.size(), 0);

    // dwell=0 behaves as 1; this also shows a new start is accepted after the abort.
    push_tick(0, -1); push_tick(1, 1); push_tick(2, 1); push_tick(3, 1); push_done(1);
    run_sweep(0, 3, 1, 0, 4, 3, 1'b0);

    // Asynchronous reset while step_tick is high.
    push_tick(26000, -1); push_tick(26005, 3);
    @(negedge clk50MHz);
    bus.start_inc = INC_W'(26000);
    bus.stop_inc  = INC_W'(26010);
    bus.step_inc  = INC_W'(5);
    bus.dwell     = DWELL_W'(3);
    bus.start     = 1'b1;
    @(negedge clk50MHz);
    bus.start = 1'b0;
    repeat (3) @(negedge clk50MHz);
    chk("pre_reset_step_tick", int'(bus.step_tick), 1);
    #3 rst = 1'b1;
    #1;
    chk("async_reset_increment", int'(bus.increment), 0);
    chk("async_reset_busy", int'(bus.busy), 0);
    chk("async_reset_step_tick", int'(bus.step_tick), 0);
    exp_q.delete();
    @(negedge clk50MHz);
    rst = 1'b0;
    repeat (5) @(negedge clk50MHz);
    chk("post_reset_busy", int'(bus.busy), 0);
    chk("post_reset_increment", int'(bus.increment), 0);

    // Normal operation resumes after the reset.
    push_tick(500, -1); push_done(2);
    run_sweep(500, 500, 7, 2, 2, 500, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
